// File: rtl/line_advance_monitor.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : line_advance_monitor
// Purpose  : Consumes the stepper-motor decoder's line_advance_tick, numbers
//            each paper line, measures the cycle interval between successive
//            line advances, detects motor stalls and queues one record per
//            line in a small FIFO read over a valid/ready interface.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk               in   system clock
//   reset             in   asynchronous, active-low reset
//   line_advance_tick in   single-cycle pulse per line advance
//   enable            in   monitor enable; low forces IDLE and ignores ticks
//   clear             in   synchronous flush of FIFO, counters and overflow
//   rec_valid         out  FIFO head holds a record
//   rec_ready         in   consumer accepts the head record
//   rec_line          out  line number of the head record
//   rec_period        out  cycles since the previous tick (head record)
//   rec_first         out  head record is the first after IDLE/STALLED
//   line_count        out  lines seen since reset/clear (wraps)
//   stalled           out  monitor is in the STALLED state
//   overflow          out  sticky: a record was dropped on a full FIFO
// ============================================================================
module line_advance_monitor #(
    parameter int LINE_WIDTH   = 16,
    parameter int PERIOD_WIDTH = 24,
    parameter int FIFO_DEPTH   = 4,
    parameter int STALL_CYCLES = 1_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    line_advance_tick,
    input  logic                    enable,
    input  logic                    clear,
    output logic                    rec_valid,
    input  logic                    rec_ready,
    output logic [LINE_WIDTH-1:0]   rec_line,
    output logic [PERIOD_WIDTH-1:0] rec_period,
    output logic                    rec_first,
    output logic [LINE_WIDTH-1:0]   line_count,
    output logic                    stalled,
    output logic                    overflow
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int REC_W = LINE_WIDTH + PERIOD_WIDTH + 1;

    localparam logic [PERIOD_WIDTH-1:0] C_STALL_MATCH = PERIOD_WIDTH'(STALL_CYCLES);
    localparam logic [PERIOD_WIDTH-1:0] C_PERIOD_MAX  = {PERIOD_WIDTH{1'b1}};
    localparam logic [PTR_W:0]          C_FIFO_FULL   = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_STALLED = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [PERIOD_WIDTH-1:0] period_q, period_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic                    overflow_q, overflow_d;
    logic                    stalled_q, stalled_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]          count_q, count_d;
    logic [REC_W-1:0]        mem_q [FIFO_DEPTH];

    logic             accept;
    logic             fifo_full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [REC_W-1:0] rec_new;
    logic [REC_W-1:0] rec_head;

    // ------------------------------------------------------------------
    // Handshake decode. A full FIFO still accepts a push when the head is
    // being popped in the same cycle, so occupancy stays constant there.
    // ------------------------------------------------------------------
    always_comb begin
        accept    = line_advance_tick && enable && !clear;
        fifo_full = (count_q == C_FIFO_FULL);
        pop       = (count_q != '0) && rec_ready && !clear;
        push      = accept && (!fifo_full || pop);
        drop      = accept && fifo_full && !pop;
        // Record layout: {first, period, line}
        rec_new   = {(state_q != ST_RUNNING), period_q, line_q};
    end

    // ------------------------------------------------------------------
    // Next-state logic: clear > enable low > tick/stall.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        period_d   = period_q;
        line_d     = line_q;
        overflow_d = overflow_q || drop;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        // FIFO bookkeeping (push is already suppressed by clear/enable)
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        if (clear) begin
            state_d    = ST_IDLE;
            period_d   = '0;
            line_d     = '0;
            overflow_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else if (!enable) begin
            // FIFO contents, line count and overflow are retained
            state_d  = ST_IDLE;
            period_d = '0;
        end else if (accept) begin
            state_d  = ST_RUNNING;
            period_d = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
            line_d   = line_q + 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    period_d = '0;
                end
                ST_RUNNING: begin
                    if (period_q == C_STALL_MATCH) begin
                        state_d = ST_STALLED;
                    end
                    if (period_q != C_PERIOD_MAX) begin
                        period_d = period_q + 1'b1;
                    end
                end
                ST_STALLED: begin
                    // Keep measuring so the eventual recovery tick still
                    // reports a (saturated) interval.
                    if (period_q != C_PERIOD_MAX) begin
                        period_d = period_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    period_d = '0;
                end
            endcase
        end

        stalled_d = (state_d == ST_STALLED);
    end

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            period_q   <= '0;
            line_q     <= '0;
            overflow_q <= 1'b0;
            stalled_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            period_q   <= period_d;
            line_q     <= line_d;
            overflow_q <= overflow_d;
            stalled_q  <= stalled_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // ------------------------------------------------------------------
    // Record storage. Reset so the head outputs read zero out of reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= rec_new;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rec_head   = mem_q[rd_ptr_q];
    assign rec_valid  = (count_q != '0);
    assign rec_line   = rec_head[LINE_WIDTH-1:0];
    assign rec_period = rec_head[LINE_WIDTH +: PERIOD_WIDTH];
    assign rec_first  = rec_head[REC_W-1];
    assign line_count = line_q;
    assign stalled    = stalled_q;
    assign overflow   = overflow_q;

endmodule
`default_nettype wire
